// File: rtl/pixel_write_buffer_if.sv
// Plot-side and frame-buffer-side signals of pixel_write_buffer, plus the
// control FSM state (fsm_state: 0 = EMPTY, 1 = ACTIVE) for observation.
interface pixel_write_buffer_if;
    logic        plot;
    logic [8:0]  x_in;
    logic [7:0]  y_in;
    logic [2:0]  color_in;
    logic        plot_ready;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ack;
    logic        idle;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        fsm_state;

    modport slave (
        input  plot, x_in, y_in, color_in, fb_ack,
        output plot_ready, fb_we, fb_addr, fb_data, idle, overflow, drop_count, fsm_state
    );

    modport master (
        output plot, x_in, y_in, color_in, fb_ack,
        input  plot_ready, fb_we, fb_addr, fb_data, idle, overflow, drop_count, fsm_state
    );
endinterface

// File: rtl/pixel_write_buffer.sv
// Pixel FIFO between the draw sequencer and the frame-buffer write port.
// Optional macro PIXEL_BOUNDS_CHECK_EN: discard (and count) off-screen plots.
module pixel_write_buffer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                 clock,
    input  logic                 resetn,
    pixel_write_buffer_if.slave  bus
);
    // Handshakes: a plot transfers on a rising edge where plot && plot_ready;
    // a frame-buffer write retires on a rising edge where fb_we && fb_ack.
    // plot_ready and fb_we are registered and never depend on plot or fb_ack.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [16:0]      ROW_W = 17'(SCREEN_W);

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  color;
    } entry_t;

    typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [16:0]      addr;
    logic             accept;
    logic             store;
    logic             pop;
    logic             plot_ready_r;
    logic             fb_we_r;
    logic             idle_r;
    logic             overflow_r;

    assign addr   = 17'(bus.y_in) * ROW_W + 17'(bus.x_in);
    assign accept = bus.plot && plot_ready_r;
    assign pop    = fb_we_r && bus.fb_ack;

`ifdef PIXEL_BOUNDS_CHECK_EN
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    logic       in_range;
    logic [7:0] drop_cnt;

    assign in_range = (bus.x_in < X_LIM) && (bus.y_in < Y_LIM);
    assign store    = accept && in_range;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (accept && !in_range && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.drop_count = drop_cnt;
`else
    assign store          = accept;
    assign bus.drop_count = '0;
`endif

    always_comb begin
        count_next = count;
        unique case ({store, pop})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    // Storage carries no reset; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (store) begin
            mem[wr_ptr] <= '{addr: addr, color: bus.color_in};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            plot_ready_r <= 1'b1;
            fb_we_r      <= 1'b0;
            idle_r       <= 1'b1;
            overflow_r   <= 1'b0;
        end else begin
            unique case (state)
                EMPTY:  if (store) state <= ACTIVE;
                ACTIVE: if (count == ONE && pop && !store) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count        <= count_next;
            plot_ready_r <= (count_next != FULL);
            fb_we_r      <= (count_next != '0);
            idle_r       <= (count_next == '0);
            if (bus.plot && !plot_ready_r) overflow_r <= 1'b1;
        end
    end

    // Outputs read zero while empty so the post-reset values are defined.
    assign head          = mem[rd_ptr];
    assign bus.fb_addr   = fb_we_r ? head.addr  : '0;
    assign bus.fb_data   = fb_we_r ? head.color : '0;
    assign bus.plot_ready = plot_ready_r;
    assign bus.fb_we     = fb_we_r;
    assign bus.idle      = idle_r;
    assign bus.overflow  = overflow_r;
    assign bus.fsm_state = (state == ACTIVE);
endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed-vector bench for pixel_write_buffer; honours PIXEL_BOUNDS_CHECK_EN.
module tb_pixel_write_buffer;
    logic clock;
    logic resetn;
    int   tests_run;
    int   tests_failed;
    logic [16:0] exp_q[$];

    pixel_write_buffer_if bus ();

    pixel_write_buffer #(.DEPTH(8), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [16:0] pix_addr(input int x, input int y);
        return 17'(y * 320 + x);
    endfunction

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        bus.plot     = 1'b0;
        bus.fb_ack   = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.color_in = '0;
        tick();
        tick();
        resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive_plot(input int x, input int y, input int c);
        bus.plot     = 1'b1;
        bus.x_in     = 9'(x);
        bus.y_in     = 8'(y);
        bus.color_in = 3'(c);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.plot_ready !== 1'b1 || bus.fb_we !== 1'b0 || bus.idle !== 1'b1 ||
            bus.overflow !== 1'b0 || bus.drop_count !== 8'd0 || bus.fsm_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: ready=%b we=%b idle=%b ovf=%b drop=%0d st=%b, required 1 0 1 0 0 0",
                     bus.plot_ready, bus.fb_we, bus.idle, bus.overflow, bus.drop_count, bus.fsm_state);
        end
        tests_run++;
        if (bus.fb_addr !== 17'd0 || bus.fb_data !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_bus: addr=%0d data=%0d, required 0 0", bus.fb_addr, bus.fb_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.fb_ack = 1'b1;
        drive_plot(5, 2, 7);
        tick();
        bus.plot = 1'b0;
        tests_run++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd645 || bus.fb_data !== 3'd7 || bus.fsm_state !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_write: we=%b addr=%0d data=%0d st=%b, required 1 645 7 1",
                     bus.fb_we, bus.fb_addr, bus.fb_data, bus.fsm_state);
        end
        tick();
        tests_run++;
        if (bus.idle !== 1'b1 || bus.fb_we !== 1'b0 || bus.fsm_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: idle=%b we=%b st=%b, required 1 0 0", bus.idle, bus.fb_we, bus.fsm_state);
        end
    endtask

    task automatic test_full_overflow();
        logic [16:0] exp_addr;
        do_reset();
        bus.fb_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_plot(i + 10, i, i);
            tests_run++;
            if (bus.plot_ready !== (i < 8)) begin
                tests_failed++;
                $display("FAIL full_ready[%0d]: ready=%b, required %b", i, bus.plot_ready, (i < 8));
            end
            if (i < 8) exp_q.push_back(pix_addr(i + 10, i));
            if (i >= 1) begin
                tests_run++;
                if (bus.fb_we !== 1'b1 || bus.fb_addr !== pix_addr(10, 0)) begin
                    tests_failed++;
                    $display("FAIL stall_hold[%0d]: we=%b addr=%0d, required 1 %0d",
                             i, bus.fb_we, bus.fb_addr, pix_addr(10, 0));
                end
            end
            tick();
        end
        bus.plot = 1'b0;
        tests_run++;
        if (bus.overflow !== 1'b1 || bus.plot_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_flag: ovf=%b ready=%b, required 1 0", bus.overflow, bus.plot_ready);
        end
        bus.fb_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_addr = exp_q.pop_front();
            tests_run++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== exp_addr || bus.fb_data !== 3'(k)) begin
                tests_failed++;
                $display("FAIL drain[%0d]: we=%b addr=%0d data=%0d, required 1 %0d %0d",
                         k, bus.fb_we, bus.fb_addr, bus.fb_data, exp_addr, k);
            end
            tick();
        end
        tests_run++;
        if (bus.idle !== 1'b1 || bus.fb_we !== 1'b0 || bus.overflow !== 1'b1 || bus.plot_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_end: idle=%b we=%b ovf=%b ready=%b, required 1 0 1 1",
                     bus.idle, bus.fb_we, bus.overflow, bus.plot_ready);
        end
    endtask

    task automatic test_back_to_back();
        int x;
        int y;
        int writes;
        do_reset();
        bus.fb_ack = 1'b1;
        writes = 0;
        for (int i = 0; i < 100; i++) begin
            x = (i * 3) % 320;
            y = (i * 7) % 240;
            drive_plot(x, y, i % 8);
            tick();
            if (bus.fb_we === 1'b1) writes++;
            tests_run++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== pix_addr(x, y) || bus.plot_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream[%0d]: we=%b addr=%0d ready=%b, required 1 %0d 1",
                         i, bus.fb_we, bus.fb_addr, bus.plot_ready, pix_addr(x, y));
            end
        end
        bus.plot = 1'b0;
        tick();
        tests_run++;
        if (writes != 100 || bus.idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_total: writes=%0d idle=%b, required 100 1", writes, bus.idle);
        end
    endtask

    task automatic test_corners();
        do_reset();
        bus.fb_ack = 1'b0;
        drive_plot(319, 239, 2);
        tick();
        drive_plot(0, 0, 5);
        tick();
        bus.plot = 1'b0;
        tests_run++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd76799 || bus.fb_data !== 3'd2) begin
            tests_failed++;
            $display("FAIL corner_max: we=%b addr=%0d data=%0d, required 1 76799 2",
                     bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        bus.fb_ack = 1'b1;
        tick();
        tests_run++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd0 || bus.fb_data !== 3'd5) begin
            tests_failed++;
            $display("FAIL corner_zero: we=%b addr=%0d data=%0d, required 1 0 5",
                     bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        do_reset();
        bus.fb_ack = 1'b0;
        drive_plot(320, 10, 1);
        tick();
        bus.plot = 1'b0;
`ifdef PIXEL_BOUNDS_CHECK_EN
        tests_run++;
        if (bus.fb_we !== 1'b0 || bus.idle !== 1'b1 || bus.drop_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL oor_drop: we=%b idle=%b drop=%0d, required 0 1 1", bus.fb_we, bus.idle, bus.drop_count);
        end
        drive_plot(5, 240, 1);
        for (int i = 0; i < 260; i++) tick();
        bus.plot = 1'b0;
        tests_run++;
        if (bus.drop_count !== 8'd255 || bus.fb_we !== 1'b0 || bus.plot_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL oor_saturate: drop=%0d we=%b ready=%b, required 255 0 1",
                     bus.drop_count, bus.fb_we, bus.plot_ready);
        end
`else
        tests_run++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd3520 || bus.drop_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL oor_store: we=%b addr=%0d drop=%0d, required 1 3520 0",
                     bus.fb_we, bus.fb_addr, bus.drop_count);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.fb_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_plot(i, 1, 3);
            tick();
        end
        bus.plot   = 1'b0;
        bus.fb_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.fb_ack = 1'b0;
        tests_run++;
        if (bus.fb_we !== 1'b1 || bus.overflow !== 1'b1 || bus.fb_addr !== pix_addr(3, 1)) begin
            tests_failed++;
            $display("FAIL burst_pre: we=%b ovf=%b addr=%0d, required 1 1 %0d",
                     bus.fb_we, bus.overflow, bus.fb_addr, pix_addr(3, 1));
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tests_run++;
        if (bus.fb_we !== 1'b0 || bus.idle !== 1'b1 || bus.plot_ready !== 1'b1 ||
            bus.overflow !== 1'b0 || bus.fsm_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_reset: we=%b idle=%b ready=%b ovf=%b st=%b, required 0 1 1 0 0",
                     bus.fb_we, bus.idle, bus.plot_ready, bus.overflow, bus.fsm_state);
        end
        tick();
        tests_run++;
        if (bus.fb_we !== 1'b0 || bus.idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_after: we=%b idle=%b, required 0 1", bus.fb_we, bus.idle);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        bus.plot     = 1'b0;
        bus.fb_ack   = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.color_in = '0;
        test_reset();
        test_single();
        test_full_overflow();
        test_back_to_back();
        test_corners();
        test_out_of_range();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
